// File: rtl/main_clock_pkg.sv
// Shared constants and BCD helpers for the main_clock wall clock.
package main_clock_pkg;

   // Active-low segment codes {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam logic [7:0] HR_MAX  = 8'h23;
   localparam logic [7:0] HR_NOON = 8'h12;

   localparam logic [7:0] ALARM_RST_HR  = 8'h06;
   localparam logic [7:0] ALARM_RST_MIN = 8'h00;

   // Two-digit BCD increment that wraps to 00 after max.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // 24-hour BCD hour to 12-hour BCD hour (00 -> 12, 13..23 -> 01..11).
   function automatic logic [7:0] to_12h(input logic [7:0] h);
      logic [4:0] bin;
      bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      if (bin == 5'd0)
         bin = 5'd12;
      else if (bin > 5'd12)
         bin = bin - 5'd12;
      return {4'(bin / 5'd10), 4'(bin % 5'd10)};
   endfunction

endpackage

// File: rtl/main_clock_seg7_decode.sv
// BCD digit to active-low seven-segment code; non-decimal nibbles blank the digit.
module seg7_decode
   import main_clock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: the default arm assigns seg on every path, so no latch is inferred.
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/main_clock.sv
// 24-hour BCD wall clock with alarm, 12/24-hour view and four seven-segment digits.
module main_clock
   import main_clock_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic       CP50,
   input  logic       nCR,
   input  logic       EN,
   input  logic       Ctrl24To12,
   input  logic       SwitchMHToS,
   input  logic       DisplayA,
   input  logic       AdjH,
   input  logic       AdjM,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic       LEDAlarm,
   output logic       LED0
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic          tick;
   logic [7:0]    sec, min, hr;
   logic [7:0]    a_min, a_hr;
   logic          adj_time;
   logic [7:0]    src_hr, disp_hr, left, right;

   assign tick     = (div == DW'(CLK_DIV - 1));
   assign adj_time = !DisplayA && (AdjH || AdjM);

   // nCR is active-high despite its name.
   always_ff @(posedge CP50 or posedge nCR) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (nCR)
         div <= '0;
      else if (tick)
         div <= '0;
      else
         div <= div + DW'(1);
   end

   always_ff @(posedge CP50 or posedge nCR) begin
      if (nCR) begin
         sec <= 8'h00;
         min <= 8'h00;
         hr  <= 8'h00;
      end else if (tick) begin
         // Adjusting the time freezes seconds and suppresses carries, even with EN=0.
         if (adj_time) begin
            if (AdjH) hr  <= bcd_inc(hr, HR_MAX);
            if (AdjM) min <= bcd_inc(min, MIN_MAX);
         end else if (EN) begin
            sec <= bcd_inc(sec, SEC_MAX);
            if (sec == SEC_MAX) begin
               min <= bcd_inc(min, MIN_MAX);
               if (min == MIN_MAX) hr <= bcd_inc(hr, HR_MAX);
            end
         end
      end
   end

   always_ff @(posedge CP50 or posedge nCR) begin
      if (nCR) begin
         a_hr  <= ALARM_RST_HR;
         a_min <= ALARM_RST_MIN;
      end else if (tick && DisplayA) begin
         if (AdjH) a_hr  <= bcd_inc(a_hr, HR_MAX);
         if (AdjM) a_min <= bcd_inc(a_min, MIN_MAX);
      end
   end

   always_ff @(posedge CP50 or posedge nCR) begin
      if (nCR)
         LEDAlarm <= 1'b0;
      else
         LEDAlarm <= (hr == a_hr) && (min == a_min);
   end

   always_comb begin
      src_hr  = DisplayA ? a_hr : hr;
      disp_hr = Ctrl24To12 ? to_12h(src_hr) : src_hr;
      if (DisplayA) begin
         left  = disp_hr;
         right = a_min;
      end else if (SwitchMHToS) begin
         left  = disp_hr;
         right = min;
      end else begin
         left  = min;
         right = sec;
      end
   end

   assign LED0 = Ctrl24To12 && (src_hr >= HR_NOON);

   seg7_decode u_hex3 (.bcd(left[7:4]),  .seg(HEX3));
   seg7_decode u_hex2 (.bcd(left[3:0]),  .seg(HEX2));
   seg7_decode u_hex1 (.bcd(right[7:4]), .seg(HEX1));
   seg7_decode u_hex0 (.bcd(right[3:0]), .seg(HEX0));

endmodule

// File: tb/tb_main_clock.sv
// Self-checking bench for main_clock: directed corner cases, a display table and random traffic.
module tb_main_clock;

   localparam int CLK_DIV = 4;

   logic       CP50 = 1'b0;
   logic       nCR = 1'b1, EN = 1'b0, Ctrl24To12 = 1'b0, SwitchMHToS = 1'b0;
   logic       DisplayA = 1'b0, AdjH = 1'b0, AdjM = 1'b0;
   logic [6:0] HEX3, HEX2, HEX1, HEX0;
   logic       LEDAlarm, LED0;

   main_clock #(.CLK_DIV(CLK_DIV)) dut (
      .CP50(CP50), .nCR(nCR), .EN(EN), .Ctrl24To12(Ctrl24To12),
      .SwitchMHToS(SwitchMHToS), .DisplayA(DisplayA), .AdjH(AdjH), .AdjM(AdjM),
      .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
      .LEDAlarm(LEDAlarm), .LED0(LED0)
   );

   always #5 CP50 = ~CP50;

   int checks = 0;
   int errors = 0;

   // Reference model: seconds of day, alarm minute of day, divider phase, alarm LED.
   int m_t, m_am, m_div;
   bit m_led;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      bit         c12, sw, da;
      logic [6:0] h3, h2, h1, h0;
      bit         led0;
   } disp_vec_t;

   disp_vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int h12(input int h, input logic c);
      if (!c)      return h;
      if (h == 0)  return 12;
      if (h > 12)  return h - 12;
      return h;
   endfunction

   task automatic model_reset();
      m_t = 0; m_am = 6 * 60; m_div = 0; m_led = 1'b0;
   endtask

   task automatic model_edge();
      bit tick;
      int h, m, s;
      if (nCR) return;
      tick  = (m_div == CLK_DIV - 1);
      m_led = ((m_t / 60) == m_am);
      m_div = tick ? 0 : m_div + 1;
      if (!tick) return;
      if (DisplayA) begin
         h = m_am / 60; m = m_am % 60;
         if (AdjH) h = (h + 1) % 24;
         if (AdjM) m = (m + 1) % 60;
         m_am = h * 60 + m;
         if (EN) m_t = (m_t + 1) % 86400;
      end else if (AdjH || AdjM) begin
         h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
         if (AdjH) h = (h + 1) % 24;
         if (AdjM) m = (m + 1) % 60;
         m_t = h * 3600 + m * 60 + s;
      end else if (EN) begin
         m_t = (m_t + 1) % 86400;
      end
   endtask

   task automatic cycle();
      @(posedge CP50);
      model_edge();
      #1;
   endtask

   // Clock until n model ticks have occurred, then one settling cycle for LEDAlarm.
   task automatic run_ticks(input int n);
      int seen = 0;
      int guard = 0;
      while (seen < n && guard < (n + 1) * CLK_DIV) begin
         if (m_div == CLK_DIV - 1) seen++;
         cycle();
         guard++;
      end
      if (seen != n) begin
         errors++;
         $display("FAIL run_ticks: got %0d ticks expected %0d", seen, n);
      end
      cycle();
   endtask

   task automatic check_all(input string tag);
      int left, right, hsrc;
      if (DisplayA) begin
         hsrc = m_am / 60; left = h12(hsrc, Ctrl24To12); right = m_am % 60;
      end else if (SwitchMHToS) begin
         hsrc = m_t / 3600; left = h12(hsrc, Ctrl24To12); right = (m_t / 60) % 60;
      end else begin
         hsrc = m_t / 3600; left = (m_t / 60) % 60; right = m_t % 60;
      end
      check({tag, ".hex3"}, 32'(HEX3), 32'(seg_tab[left / 10]));
      check({tag, ".hex2"}, 32'(HEX2), 32'(seg_tab[left % 10]));
      check({tag, ".hex1"}, 32'(HEX1), 32'(seg_tab[right / 10]));
      check({tag, ".hex0"}, 32'(HEX0), 32'(seg_tab[right % 10]));
      check({tag, ".led0"}, 32'(LED0), 32'(Ctrl24To12 && hsrc >= 12));
      check({tag, ".ledalarm"}, 32'(LEDAlarm), 32'(m_led));
   endtask

   task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
      check({tag, ".hex3"}, 32'(HEX3), 32'(e3));
      check({tag, ".hex2"}, 32'(HEX2), 32'(e2));
      check({tag, ".hex1"}, 32'(HEX1), 32'(e1));
      check({tag, ".hex0"}, 32'(HEX0), 32'(e0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Display table for time 13:01:00 with alarm 06:00.
      vecs[0] = '{c12: 0, sw: 1, da: 0, h3: 7'h79, h2: 7'h30, h1: 7'h40, h0: 7'h79, led0: 0};
      vecs[1] = '{c12: 1, sw: 1, da: 0, h3: 7'h40, h2: 7'h79, h1: 7'h40, h0: 7'h79, led0: 1};
      vecs[2] = '{c12: 0, sw: 0, da: 0, h3: 7'h40, h2: 7'h79, h1: 7'h40, h0: 7'h40, led0: 0};
      vecs[3] = '{c12: 0, sw: 0, da: 1, h3: 7'h40, h2: 7'h02, h1: 7'h40, h0: 7'h40, led0: 0};
      vecs[4] = '{c12: 1, sw: 0, da: 1, h3: 7'h40, h2: 7'h02, h1: 7'h40, h0: 7'h40, led0: 0};

      // Reset held
      model_reset();
      repeat (3) @(posedge CP50);
      #1;
      check_hex("reset", 7'h40, 7'h40, 7'h40, 7'h40);
      check("reset.ledalarm", 32'(LEDAlarm), 32'd0);
      check("reset.led0", 32'(LED0), 32'd0);

      // First tick lands exactly CLK_DIV cycles after release
      nCR = 1'b0; EN = 1'b1; SwitchMHToS = 1'b0;
      repeat (CLK_DIV - 1) cycle();
      check("pre_tick.hex0", 32'(HEX0), 32'h40);
      cycle();
      check("first_tick.hex0", 32'(HEX0), 32'h79);
      check_all("first_tick");

      // Preset 23:59:00 by adjust with EN=0, then roll over
      nCR = 1'b1; #1; model_reset();
      cycle();
      nCR = 1'b0; EN = 1'b0; AdjH = 1'b1; AdjM = 1'b1;
      run_ticks(23);
      AdjH = 1'b0;
      run_ticks(36);
      AdjM = 1'b0; SwitchMHToS = 1'b1; #1;
      check_hex("preset_2359", 7'h24, 7'h30, 7'h12, 7'h10);
      check_all("preset_2359");
      EN = 1'b1;
      run_ticks(60);
      check_hex("rollover", 7'h40, 7'h40, 7'h40, 7'h40);
      check_all("rollover");

      // Freeze and minute adjust with EN=0, including the 59->00 wrap
      SwitchMHToS = 1'b0; EN = 1'b0;
      run_ticks(20);
      check_hex("freeze", 7'h40, 7'h40, 7'h40, 7'h40);
      SwitchMHToS = 1'b1; AdjM = 1'b1;
      run_ticks(3);
      check_hex("adjm3", 7'h40, 7'h40, 7'h40, 7'h30);
      run_ticks(55);
      check_all("adjm58");
      run_ticks(3);
      AdjM = 1'b0;
      check_hex("adjm_wrap", 7'h40, 7'h40, 7'h40, 7'h79);
      check_all("adjm_wrap");

      // Hours to 13, then the display-mode table
      AdjH = 1'b1;
      run_ticks(13);
      AdjH = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Ctrl24To12 = vecs[i].c12; SwitchMHToS = vecs[i].sw; DisplayA = vecs[i].da;
         #1;
         check_hex($sformatf("vec%0d", i), vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0);
         check($sformatf("vec%0d.led0", i), 32'(LED0), 32'(vecs[i].led0));
      end

      // Hour 00 shows as 12 in 12-hour mode, PM off
      Ctrl24To12 = 1'b1; SwitchMHToS = 1'b1; DisplayA = 1'b0; AdjH = 1'b1;
      run_ticks(11);
      AdjH = 1'b0;
      check_hex("h12_midnight", 7'h79, 7'h24, 7'h40, 7'h79);
      check("h12_midnight.led0", 32'(LED0), 32'd0);
      Ctrl24To12 = 1'b0;

      // Alarm to 07:00, then time to 07:00 and watch the LED for one minute
      DisplayA = 1'b1; AdjH = 1'b1;
      run_ticks(1);
      AdjH = 1'b0;
      check("alarm0700.hex3", 32'(HEX3), 32'h40);
      check("alarm0700.hex2", 32'(HEX2), 32'h78);
      check_all("alarm0700");
      DisplayA = 1'b0; AdjH = 1'b1;
      run_ticks(7);
      AdjH = 1'b0; AdjM = 1'b1;
      run_ticks(59);
      AdjM = 1'b0;
      check("alarm_hit", 32'(LEDAlarm), 32'd1);
      EN = 1'b1;
      run_ticks(59);
      check("alarm_hold", 32'(LEDAlarm), 32'd1);
      check_all("alarm_hold");
      run_ticks(1);
      check("alarm_clear", 32'(LEDAlarm), 32'd0);
      check_all("alarm_clear");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (i % 8 == 0) begin
            EN          = 1'($urandom_range(0, 1));
            Ctrl24To12  = 1'($urandom_range(0, 1));
            SwitchMHToS = 1'($urandom_range(0, 1));
            DisplayA    = ($urandom_range(0, 3) == 0);
            AdjH        = ($urandom_range(0, 5) == 0);
            AdjM        = ($urandom_range(0, 4) == 0);
         end
         cycle();
         check_all("rand");
      end

      // Async reset between edges, then restart
      EN = 1'b1; AdjH = 1'b0; AdjM = 1'b0; DisplayA = 1'b0; Ctrl24To12 = 1'b0;
      SwitchMHToS = 1'b0;
      repeat (2) cycle();
      @(negedge CP50);
      nCR = 1'b1; model_reset();
      #1;
      check_hex("async_rst", 7'h40, 7'h40, 7'h40, 7'h40);
      check("async_rst.ledalarm", 32'(LEDAlarm), 32'd0);
      check("async_rst.led0", 32'(LED0), 32'd0);
      cycle();
      nCR = 1'b0;
      repeat (CLK_DIV) cycle();
      check("restart.hex0", 32'(HEX0), 32'h79);
      check_all("restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
